demux1x4_stream_nbit: RTL

//  Registered 1-to-4 stream demultiplexer; the distributing counterpart to the 4:1 mux.

---
 rtl/demux1x4_stream_nbit.sv | 78 +++++++
 1 files changed

// File: rtl/demux1x4_stream_nbit.sv
// demux1x4_stream_nbit
// Registered 1-to-4 stream demultiplexer. One valid/ready input fans out to
// four one-deep output slots. The target slot is picked by s, or by an
// internal round-robin pointer when rr_en is high.
module demux1x4_stream_nbit #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] i,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [1:0]   s,
    input  logic         rr_en,
    output logic [n-1:0] f0,
    output logic [n-1:0] f1,
    output logic [n-1:0] f2,
    output logic [n-1:0] f3,
    output logic [3:0]   f_valid,
    input  logic [3:0]   f_ready
);

    logic [n-1:0] data_q [4];
    logic [n-1:0] data_d [4];
    logic [3:0]   vld_q;
    logic [3:0]   vld_d;
    logic [1:0]   ptr_q;
    logic [1:0]   ptr_d;
    logic [1:0]   tgt;
    logic         accept;

    // Target selection, ready and next-state for slots and round-robin pointer.
    // i_ready depends only on registered state, s, rr_en and f_ready, never on i_valid.
    always_comb begin
        tgt     = rr_en ? ptr_q : s;
        i_ready = ~vld_q[tgt] | f_ready[tgt];
        accept  = i_valid & i_ready;

        // Every occupied slot whose consumer is ready drains this cycle.
        vld_d   = vld_q & ~f_ready;
        data_d  = data_q;
        ptr_d   = ptr_q;

        // A load into the target overrides its drain, so back-to-back words
        // into one channel keep it full at one word per cycle.
        if (accept) begin
            vld_d[tgt]  = 1'b1;
            data_d[tgt] = i;
            if (rr_en) begin
                ptr_d = ptr_q + 2'd1;
            end
        end
    end

    // State register; reset discards any pending words and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= 4'b0000;
            ptr_q <= 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    assign f0      = data_q[0];
    assign f1      = data_q[1];
    assign f2      = data_q[2];
    assign f3      = data_q[3];
    assign f_valid = vld_q;

endmodule
